// File: rtl/hx8352_pkg.sv
// Shared constants, register map and state encoding for the HX8352 bus responder.
package hx8352_pkg;

    localparam int DEF_H_RES = 240;
    localparam int DEF_V_RES = 400;

    localparam logic [7:0] IDX_ID   = 8'h00;
    localparam logic [7:0] IDX_SC_H = 8'h02;
    localparam logic [7:0] IDX_SC_L = 8'h03;
    localparam logic [7:0] IDX_EC_H = 8'h04;
    localparam logic [7:0] IDX_EC_L = 8'h05;
    localparam logic [7:0] IDX_SP_H = 8'h06;
    localparam logic [7:0] IDX_SP_L = 8'h07;
    localparam logic [7:0] IDX_EP_H = 8'h08;
    localparam logic [7:0] IDX_EP_L = 8'h09;
    localparam logic [7:0] IDX_GRAM = 8'h22;

    localparam logic [15:0] ID_CODE = 16'h0052;

    typedef enum logic {
        ST_CMD  = 1'b0,
        ST_GRAM = 1'b1
    } state_e;

    typedef struct packed {
        logic [8:0] sc;
        logic [8:0] ec;
        logic [8:0] sp;
        logic [8:0] ep;
    } win_t;

    // Used for both axes; >= makes inverted windows collapse to the start point.
    function automatic logic [8:0] cursor_step(input logic [8:0] pos,
                                               input logic [8:0] lo,
                                               input logic [8:0] hi);
        return (pos >= hi) ? lo : pos + 9'd1;
    endfunction

endpackage

// File: rtl/hx8352_bus_responder_if.sv
// 8080-style parallel panel bus; the initiator is the master, the panel model the slave.
interface hx8352_bus_responder_if;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic        lcd_rst;
    logic [15:0] lcd_data_in;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;

    modport master (
        output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/hx8352_strobe_sync.sv
// Multi-flop synchronizer for a bus word, with edge detect on its low EDGE_W bits.
module hx8352_strobe_sync #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter int             EDGE_W  = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      d_i,
    output logic [W-1:0]      q_o,
    output logic [EDGE_W-1:0] rise_o,
    output logic [EDGE_W-1:0] fall_o
);

    logic [STAGES-1:0][W-1:0] stg_q;
    logic [EDGE_W-1:0]        prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_q  <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL[EDGE_W-1:0];
        end else begin
            stg_q  <= {stg_q[STAGES-2:0], d_i};
            prev_q <= stg_q[STAGES-1][EDGE_W-1:0];
        end
    end

    assign q_o    = stg_q[STAGES-1];
    assign rise_o = q_o[EDGE_W-1:0] & ~prev_q;
    assign fall_o = ~q_o[EDGE_W-1:0] & prev_q;

endmodule

// File: rtl/hx8352_bus_responder.sv
// HX8352 panel-side bus responder: index/register writes, GRAM pixel stream with
// window cursor, register read-back and strobe-overlap detection.
module hx8352_bus_responder
    import hx8352_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES
) (
    input  logic                     clk,
    input  logic                     rst,
    hx8352_bus_responder_if.slave    bus,
    output logic                     reg_wr_valid,
    output logic [7:0]               reg_index,
    output logic [7:0]               reg_data,
    output logic                     pixel_valid,
    output logic [7:0]               pixel_x,
    output logic [8:0]               pixel_y,
    output logic [15:0]              pixel_data,
    output logic                     gram_mode,
    output logic                     protocol_err
);

    localparam logic [8:0]  H_LIM    = 9'(H_RES);
    localparam logic [8:0]  V_LIM    = 9'(V_RES);
    // Bit order {data, lcd_rst, rs, cs, rd, wr}; strobes idle high, rs idles low.
    localparam logic [20:0] SYNC_RST = {16'h0000, 5'b10111};

    logic [20:0] sq;
    logic        wr_rise;
    logic        unused_wr_fall;

    hx8352_strobe_sync #(
        .W      (21),
        .STAGES (SYNC_STAGES),
        .EDGE_W (1),
        .RST_VAL(SYNC_RST)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    ({bus.lcd_data_in, bus.lcd_rst, bus.lcd_rs, bus.lcd_cs, bus.lcd_rd, bus.lcd_wr}),
        .q_o    (sq),
        .rise_o (wr_rise),
        .fall_o (unused_wr_fall)
    );

    logic        wr_s, rd_s, cs_s, rs_s, lrst_s;
    logic [15:0] data_s;
    assign wr_s   = sq[0];
    assign rd_s   = sq[1];
    assign cs_s   = sq[2];
    assign rs_s   = sq[3];
    assign lrst_s = sq[4];
    assign data_s = sq[20:5];

    logic srst;
    assign srst = !rst || !lrst_s;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    win_t        win_q, win_d;
    logic [8:0]  cx_q, cx_d, cy_q, cy_d;
    logic        ev_q, ev_d, ev_rs_q, ev_rs_d;
    logic [15:0] ev_data_q, ev_data_d;
    logic        rwv_q, rwv_d;
    logic [7:0]  rdat_q, rdat_d;
    logic        pv_q, pv_d;
    logic [7:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic [15:0] pd_q, pd_d;
    logic        ovl_q, ovl_d, perr_q, perr_d;
    logic        oe_q, oe_d;
    logic [15:0] dout_q, dout_d, rdmux;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= ST_CMD;
            idx_q     <= 8'h00;
            win_q     <= '{sc: 9'd0, ec: 9'(H_RES - 1), sp: 9'd0, ep: 9'(V_RES - 1)};
            cx_q      <= 9'd0;
            cy_q      <= 9'd0;
            ev_q      <= 1'b0;
            ev_rs_q   <= 1'b0;
            ev_data_q <= 16'h0000;
            rwv_q     <= 1'b0;
            rdat_q    <= 8'h00;
            pv_q      <= 1'b0;
            px_q      <= 8'h00;
            py_q      <= 9'd0;
            pd_q      <= 16'h0000;
            ovl_q     <= 1'b0;
            perr_q    <= 1'b0;
            oe_q      <= 1'b0;
            dout_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            win_q     <= win_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ev_q      <= ev_d;
            ev_rs_q   <= ev_rs_d;
            ev_data_q <= ev_data_d;
            rwv_q     <= rwv_d;
            rdat_q    <= rdat_d;
            pv_q      <= pv_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pd_q      <= pd_d;
            ovl_q     <= ovl_d;
            perr_q    <= perr_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
        end
    end

    always_comb begin
        unique case (idx_q)
            IDX_ID:   rdmux = ID_CODE;
            IDX_SC_H: rdmux = {15'b0, win_q.sc[8]};
            IDX_SC_L: rdmux = {8'b0, win_q.sc[7:0]};
            IDX_EC_H: rdmux = {15'b0, win_q.ec[8]};
            IDX_EC_L: rdmux = {8'b0, win_q.ec[7:0]};
            IDX_SP_H: rdmux = {15'b0, win_q.sp[8]};
            IDX_SP_L: rdmux = {8'b0, win_q.sp[7:0]};
            IDX_EP_H: rdmux = {15'b0, win_q.ep[8]};
            IDX_EP_L: rdmux = {8'b0, win_q.ep[7:0]};
            default:  rdmux = 16'h0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        win_d     = win_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        // Strobe edge is captured here and decoded on the following cycle.
        ev_d      = wr_rise && !cs_s && rd_s;
        ev_rs_d   = rs_s;
        ev_data_d = data_s;
        rwv_d     = 1'b0;
        rdat_d    = rdat_q;
        pv_d      = 1'b0;
        px_d      = px_q;
        py_d      = py_q;
        pd_d      = pd_q;

        if (ev_q) begin
            if (!ev_rs_q) begin
                idx_d = ev_data_q[7:0];
                if (ev_data_q[7:0] == IDX_GRAM) begin
                    state_d = ST_GRAM;
                    cx_d    = win_q.sc;
                    cy_d    = win_q.sp;
                end else begin
                    state_d = ST_CMD;
                end
            end else if (state_q == ST_CMD) begin
                rwv_d  = 1'b1;
                rdat_d = ev_data_q[7:0];
                case (idx_q)
                    IDX_SC_H: win_d.sc[8]   = ev_data_q[0];
                    IDX_SC_L: win_d.sc[7:0] = ev_data_q[7:0];
                    IDX_EC_H: win_d.ec[8]   = ev_data_q[0];
                    IDX_EC_L: win_d.ec[7:0] = ev_data_q[7:0];
                    IDX_SP_H: win_d.sp[8]   = ev_data_q[0];
                    IDX_SP_L: win_d.sp[7:0] = ev_data_q[7:0];
                    IDX_EP_H: win_d.ep[8]   = ev_data_q[0];
                    IDX_EP_L: win_d.ep[7:0] = ev_data_q[7:0];
                    default:  ;
                endcase
            end else begin
                // Off-panel cursor positions still consume a write.
                if (cx_q < H_LIM && cy_q < V_LIM) begin
                    pv_d = 1'b1;
                    px_d = cx_q[7:0];
                    py_d = cy_q;
                    pd_d = ev_data_q;
                end
                cx_d = cursor_step(cx_q, win_q.sc, win_q.ec);
                if (cx_q >= win_q.ec) cy_d = cursor_step(cy_q, win_q.sp, win_q.ep);
            end
        end

        ovl_d  = !cs_s && !wr_s && !rd_s;
        perr_d = ovl_d && !ovl_q;
        oe_d   = !cs_s && !rd_s && wr_s;
        dout_d = oe_d ? rdmux : 16'h0000;
    end

    assign bus.lcd_data_out = dout_q;
    assign bus.lcd_data_oe  = oe_q;
    assign reg_wr_valid     = rwv_q;
    assign reg_index        = idx_q;
    assign reg_data         = rdat_q;
    assign pixel_valid      = pv_q;
    assign pixel_x          = px_q;
    assign pixel_y          = py_q;
    assign pixel_data       = pd_q;
    assign gram_mode        = (state_q == ST_GRAM);
    assign protocol_err     = perr_q;

endmodule

// File: tb/tb_hx8352_bus_responder.sv
// Directed bench for hx8352_bus_responder with a pixel/register scoreboard.
module tb_hx8352_bus_responder;
    import hx8352_pkg::*;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] dat;
    } reg_t;

    logic        clk;
    logic        rst;
    logic        reg_wr_valid;
    logic [7:0]  reg_index;
    logic [7:0]  reg_data;
    logic        pixel_valid;
    logic [7:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [15:0] pixel_data;
    logic        gram_mode;
    logic        protocol_err;

    hx8352_bus_responder_if bus ();

    hx8352_bus_responder #(
        .SYNC_STAGES(2),
        .H_RES      (240),
        .V_RES      (400)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .reg_wr_valid (reg_wr_valid),
        .reg_index    (reg_index),
        .reg_data     (reg_data),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_data   (pixel_data),
        .gram_mode    (gram_mode),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   perr_cnt = 0;
    int   oe_cnt = 0;
    int   pix_cnt = 0;
    pix_t pix_q[$];
    reg_t reg_q[$];
    pix_t mon_pix;
    reg_t mon_reg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (protocol_err === 1'b1) perr_cnt++;
        if (bus.lcd_data_oe === 1'b1) oe_cnt++;
        if (pixel_valid === 1'b1) begin
            pix_cnt++;
            chk("pixel_expected", 64'(pix_q.size() != 0), 64'd1);
            if (pix_q.size() != 0) begin
                mon_pix = pix_q.pop_front();
                chk("pixel", 64'({pixel_x, pixel_y, pixel_data}), 64'(mon_pix));
            end
        end
        if (reg_wr_valid === 1'b1) begin
            chk("reg_expected", 64'(reg_q.size() != 0), 64'd1);
            if (reg_q.size() != 0) begin
                mon_reg = reg_q.pop_front();
                chk("reg_write", 64'({reg_index, reg_data}), 64'(mon_reg));
            end
        end
    end

    task automatic wr_bus(input logic rs, input logic [15:0] d);
        @(negedge clk);
        bus.lcd_cs = 1'b0;
        bus.lcd_rs = rs;
        bus.lcd_data_in = d;
        bus.lcd_wr = 1'b0;
        repeat (2) @(negedge clk);
        bus.lcd_wr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr_idx(input logic [7:0] idx);
        wr_bus(1'b0, {8'h00, idx});
    endtask

    task automatic set_reg(input logic [7:0] idx, input logic [7:0] val);
        wr_idx(idx);
        reg_q.push_back('{idx: idx, dat: val});
        wr_bus(1'b1, {8'hA5, val});
    endtask

    task automatic set_win(input logic [8:0] sc, input logic [8:0] ec,
                           input logic [8:0] sp, input logic [8:0] ep);
        set_reg(IDX_SC_H, {7'b0, sc[8]});
        set_reg(IDX_SC_L, sc[7:0]);
        set_reg(IDX_EC_H, {7'b0, ec[8]});
        set_reg(IDX_EC_L, ec[7:0]);
        set_reg(IDX_SP_H, {7'b0, sp[8]});
        set_reg(IDX_SP_L, sp[7:0]);
        set_reg(IDX_EP_H, {7'b0, ep[8]});
        set_reg(IDX_EP_L, ep[7:0]);
    endtask

    task automatic pix(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        pix_q.push_back('{x: x, y: y, d: d});
        wr_bus(1'b1, d);
    endtask

    task automatic do_read(input string tag, input logic [15:0] exp);
        @(negedge clk);
        bus.lcd_cs = 1'b0;
        bus.lcd_rs = 1'b1;
        bus.lcd_rd = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, "_oe"}, 64'(bus.lcd_data_oe), 64'd1);
        chk({tag, "_data"}, 64'(bus.lcd_data_out), 64'(exp));
        bus.lcd_rd = 1'b1;
        repeat (5) @(negedge clk);
        chk({tag, "_oe_off"}, 64'(bus.lcd_data_oe), 64'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (pix_q.size() != 0 || reg_q.size() != 0); i++)
            @(negedge clk);
        chk({tag, "_pix_left"}, 64'(pix_q.size()), 64'd0);
        chk({tag, "_reg_left"}, 64'(reg_q.size()), 64'd0);
        pix_q.delete();
        reg_q.delete();
    endtask

    initial begin
        int n0, p0, o0;
        bus.lcd_cs = 1'b1;
        bus.lcd_rs = 1'b0;
        bus.lcd_wr = 1'b1;
        bus.lcd_rd = 1'b1;
        bus.lcd_rst = 1'b1;
        bus.lcd_data_in = 16'h0000;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_gram_mode", 64'(gram_mode), 64'd0);
        chk("rst_reg_index", 64'(reg_index), 64'd0);
        chk("rst_oe", 64'(bus.lcd_data_oe), 64'd0);
        chk("rst_dout", 64'(bus.lcd_data_out), 64'd0);
        chk("rst_pulses", 64'({pixel_valid, reg_wr_valid, protocol_err}), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Default window read-back: EC=239, EP=399.
        wr_idx(IDX_EC_L);
        do_read("rd_ec_default", 16'h00EF);
        wr_idx(IDX_EP_H);
        do_read("rd_ep_h_default", 16'h0001);

        // Basic GRAM stream from the reset cursor.
        wr_idx(IDX_GRAM);
        chk("gram_entry", 64'(gram_mode), 64'd1);
        pix(8'd0, 9'd0, 16'hF800);
        pix(8'd1, 9'd0, 16'h07E0);
        pix(8'd2, 9'd0, 16'h001F);
        drain("basic");

        // Small window with x and y wrap.
        set_win(9'd10, 9'd11, 9'd5, 9'd6);
        chk("win_cmd_mode", 64'(gram_mode), 64'd0);
        wr_idx(IDX_GRAM);
        pix(8'd10, 9'd5, 16'h1000);
        pix(8'd11, 9'd5, 16'h1001);
        pix(8'd10, 9'd6, 16'h1002);
        pix(8'd11, 9'd6, 16'h1003);
        pix(8'd10, 9'd5, 16'h1004);
        drain("window");

        // Last two rows of the panel: end-of-frame corner then wrap to the window start.
        set_win(9'd0, 9'd239, 9'd398, 9'd399);
        wr_idx(IDX_GRAM);
        for (int y = 398; y <= 399; y++)
            for (int x = 0; x < 240; x++)
                pix(8'(x), 9'(y), 16'(y * 240 + x));
        pix(8'd0, 9'd398, 16'hBEEF);
        drain("frame");

        // Column 240 is off-panel: write consumed, no pulse.
        set_win(9'd239, 9'd240, 9'd0, 9'd0);
        wr_idx(IDX_GRAM);
        n0 = pix_cnt;
        pix(8'd239, 9'd0, 16'h0A0A);
        wr_bus(1'b1, 16'h0B0B);
        pix(8'd239, 9'd0, 16'h0C0C);
        drain("offpanel");
        chk("offpanel_count", 64'(pix_cnt - n0), 64'd2);

        // Inverted window: every pixel lands on (SC, SP).
        set_win(9'd5, 9'd3, 9'd2, 9'd1);
        wr_idx(IDX_GRAM);
        pix(8'd5, 9'd2, 16'h2001);
        pix(8'd5, 9'd2, 16'h2002);
        pix(8'd5, 9'd2, 16'h2003);
        drain("inverted");

        // Register read-back.
        set_reg(IDX_EC_L, 8'hEF);
        do_read("rd_ec_l", 16'h00EF);
        wr_idx(IDX_ID);
        do_read("rd_id", 16'h0052);
        set_reg(IDX_EP_H, 8'h01);
        do_read("rd_ep_h", 16'h0001);
        wr_idx(IDX_EP_L);
        do_read("rd_ep_l", 16'h0001);
        wr_idx(8'h30);
        do_read("rd_other", 16'h0000);
        drain("readback");

        // Simultaneous wr/rd: one error pulse, no drive, write lands.
        wr_idx(IDX_SC_L);
        p0 = perr_cnt;
        o0 = oe_cnt;
        reg_q.push_back('{idx: IDX_SC_L, dat: 8'h77});
        @(negedge clk);
        bus.lcd_cs = 1'b0;
        bus.lcd_rs = 1'b1;
        bus.lcd_data_in = 16'h0077;
        bus.lcd_wr = 1'b0;
        bus.lcd_rd = 1'b0;
        repeat (6) @(negedge clk);
        bus.lcd_wr = 1'b1;
        bus.lcd_rd = 1'b1;
        repeat (6) @(negedge clk);
        drain("overlap");
        chk("overlap_perr", 64'(perr_cnt - p0), 64'd1);
        chk("overlap_oe", 64'(oe_cnt - o0), 64'd0);
        do_read("rd_overlap_commit", 16'h0077);

        // Reset while a GRAM write is in flight.
        wr_idx(IDX_GRAM);
        pix(8'd119, 9'd2, 16'h3333);
        drain("pre_reset");
        n0 = pix_cnt;
        @(negedge clk);
        bus.lcd_data_in = 16'h5555;
        bus.lcd_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.lcd_wr = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midreset_gram", 64'(gram_mode), 64'd0);
        chk("midreset_index", 64'(reg_index), 64'd0);
        reg_q.push_back('{idx: 8'h00, dat: 8'hCD});
        wr_bus(1'b1, 16'hABCD);
        drain("post_reset");
        chk("midreset_no_pixel", 64'(pix_cnt - n0), 64'd0);

        // Panel reset pin behaves like rst.
        wr_idx(IDX_GRAM);
        chk("lrst_pre_gram", 64'(gram_mode), 64'd1);
        @(negedge clk);
        bus.lcd_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("lrst_gram", 64'(gram_mode), 64'd0);
        chk("lrst_index", 64'(reg_index), 64'd0);
        bus.lcd_rst = 1'b1;
        bus.lcd_cs = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
